memory_delay_unit: RTL and testbench
====================================

Name:
memory_delay_unit

Overview:
- Avalon-MM pass-through bridge between an upstream master (s_* slave port) and downstream memory (m_* master port).
- When enabled, every read/write is stalled by a programmable number of clock cycles before it is forwarded downstream. Used to emulate slow memory for timing/fingerprinting experiments.
- When disabled, the bridge is a zero-latency combinational pass-through.
- Configured through a small CSR slave port.

Parameters:
- ADDR_W, 32, s/m address width.
- DATA_W, 32, s/m data width; byteenable width is DATA_W/8.
- CNT_W, 32, delay counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- csr_address  in  3  CSR word index
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  CSR read data, combinational
- s_address  in  ADDR_W  upstream address
- s_read  in  1  upstream read request
- s_write  in  1  upstream write request
- s_writedata  in  DATA_W  upstream write data
- s_byteenable  in  DATA_W/8  upstream byte enables
- s_readdata  out  DATA_W  upstream read data
- s_waitrequest  out  1  upstream stall
- m_address  out  ADDR_W  downstream address
- m_read  out  1  downstream read
- m_write  out  1  downstream write
- m_writedata  out  DATA_W  downstream write data
- m_byteenable  out  DATA_W/8  downstream byte enables
- m_readdata  in  DATA_W  downstream read data
- m_waitrequest  in  1  downstream stall

Behaviour:
- CSR map (csr_address):
  - 0 CTRL: bit0 = enable; other bits write-ignored, read 0.
  - 4 DELAY: CNT_W-bit stall count N.
  - All other addresses read 0; writes to them are ignored.
- CSR writes take effect on the clk edge where csr_write=1. csr_readdata is combinational from csr_address.
- Reset (reset=0), applied asynchronously:
  - enable=0, DELAY=0, FSM=IDLE, counter=0.
  - While in reset: m_read=0, m_write=0, s_waitrequest=1.
- Address, writedata and byteenable always pass through combinationally from s_* to m_*. s_readdata=m_readdata always.
- Disabled mode (enable=0 and FSM in IDLE):
  - m_read=s_read, m_write=s_write, s_waitrequest=m_waitrequest.
- FSM states: IDLE, DELAY, ISSUE.
- IDLE with enable=1:
  - m_read=m_write=0.
  - s_waitrequest=1 whenever s_read or s_write is asserted, otherwise 0.
  - On a request: load counter with N and go to DELAY; if N=0, go directly to ISSUE.
- DELAY:
  - m_read=m_write=0, s_waitrequest=1, counter decrements each cycle.
  - Go to ISSUE on the cycle the counter equals 1. Exactly N cycles are spent in DELAY.
- ISSUE:
  - m_read=s_read, m_write=s_write, s_waitrequest=m_waitrequest.
  - Return to IDLE on the edge where m_waitrequest=0 (transfer accepted).
  - If the master drops its request in ISSUE, return to IDLE.
- Latency: request first seen in cycle 0 (IDLE), forwarded downstream at cycle N+1 (N≥1) or cycle 1 (N=0). Completion then follows downstream m_waitrequest.
- Enable and DELAY changes mid-transaction affect only the next transaction. The in-flight transaction keeps its loaded count, and the FSM finishes via ISSUE even if enable is cleared.
- s_read and s_write both asserted is illegal upstream; treat it as a write (m_read forced 0).
- Back-to-back requests: each one incurs the full delay again; there is no pipelining.

Decomposition:
- Shared package: CSR address constants (CTRL=0, DELAY=4), CTRL enable bit index, FSM state enum.
- One natural sub-module: memory_delay_csr (CSR register file and readback); FSM, counter and muxing stay in the top.

Test Plan:
- Reset then read CSR 0 and 4 -> both 0. Issue s_write with enable=0 -> m_write same cycle, s_waitrequest follows m_waitrequest.
- Write DELAY=0x1F, CTRL=1, then hold s_write until accepted (downstream: m_waitrequest=0 whenever m_write=1) -> m_write stays 0 for 31 cycles after IDLE, asserts at cycle 32, s_waitrequest falls in that same cycle, back to IDLE.
- Same configuration, s_read with downstream stall of 3 cycles and m_readdata=0xA5A5A5A5 -> m_read at cycle 32, s_waitrequest low at cycle 35, s_readdata=0xA5A5A5A5.
- Write CTRL=0 then repeat write and read -> zero added latency, m_write/m_read mirror s_write/s_read.
- DELAY=0, enable=1 -> request forwarded at cycle 1. Write CTRL=0 during DELAY -> the in-flight transfer still completes after the full N cycles.
- Assert reset mid-DELAY -> immediately m_write=0, s_waitrequest=1; after release, CSRs read 0 and the block is in pass-through mode.

Source files
------------

// File: rtl/memory_delay_unit_pkg.sv
// Shared definitions for the memory delay bridge: CSR word map, CTRL bit
// positions and the request-gating FSM states.
package memory_delay_unit_pkg;

  localparam logic [2:0] CSR_CTRL    = 3'd0;
  localparam logic [2:0] CSR_DELAY   = 3'd4;
  localparam int         CTRL_EN_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/memory_delay_csr.sv
// CSR register file for the memory delay bridge: enable flag, stall count,
// and combinational readback.
module memory_delay_csr
  import memory_delay_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       csr_address,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  output logic [31:0]      csr_readdata,
  output logic             enable,
  output logic [CNT_W-1:0] delay
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= 1'b0;
      delay  <= '0;
    end else if (csr_write) begin
      case (csr_address)
        CSR_CTRL:  enable <= csr_writedata[CTRL_EN_BIT];
        CSR_DELAY: delay  <= CNT_W'(csr_writedata);
        default:   ;
      endcase
    end
  end

  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      CSR_CTRL:  csr_readdata[CTRL_EN_BIT] = enable;
      CSR_DELAY: csr_readdata = 32'(delay);
      default:   ;
    endcase
  end

endmodule

// File: rtl/memory_delay_unit.sv
// Avalon-MM bridge that stalls each upstream request by a programmable count
// before forwarding it downstream; a plain pass-through when disabled.
module memory_delay_unit
  import memory_delay_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          csr_address,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic                csr_read,
  output logic [31:0]         csr_readdata,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest
);

  logic             enable;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req;
  state_t           state, state_nxt;

  // Readback is purely address-decoded, so the read strobe carries no information.
  logic unused_csr_read;
  assign unused_csr_read = csr_read;

  memory_delay_csr #(.CNT_W(CNT_W)) u_csr (
    .clk          (clk),
    .reset        (reset),
    .csr_address  (csr_address),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata),
    .csr_readdata (csr_readdata),
    .enable       (enable),
    .delay        (delay)
  );

  assign m_address    = s_address;
  assign m_writedata  = s_writedata;
  assign m_byteenable = s_byteenable;
  assign s_readdata   = m_readdata;
  assign req          = s_read | s_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_waitrequest = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          m_read        = s_read & ~s_write;
          m_write       = s_write;
          s_waitrequest = m_waitrequest;
        end else begin
          s_waitrequest = req;
          if (req) begin
            if (delay == '0) begin
              state_nxt = ST_ISSUE;
            end else begin
              state_nxt = ST_DELAY;
              cnt_nxt   = delay;
            end
          end
        end
      end
      ST_DELAY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        m_read        = s_read & ~s_write;
        m_write       = s_write;
        s_waitrequest = m_waitrequest;
        if (!req || !m_waitrequest) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset blocks the downstream strobes immediately, not just at the next edge.
    if (!reset) begin
      m_read        = 1'b0;
      m_write       = 1'b0;
      s_waitrequest = 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_delay_unit.sv
// Randomized self-checking bench for memory_delay_unit with a cycle-level
// latency model and a stalling downstream responder.
module tb_memory_delay_unit;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        csr_address;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic              csr_read;
  logic [31:0]       csr_readdata;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic [DATA_W-1:0] s_readdata;
  logic              s_waitrequest;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic [DATA_W-1:0] m_readdata;
  logic              m_waitrequest;

  int n_chk = 0;
  int n_fail = 0;
  int seen = 0;
  int stall_cfg = 0;
  logic        en_m;
  logic [31:0] delay_m;

  int          f, dn, ef;
  logic [31:0] r;
  bit          p, q;

  memory_delay_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  // Downstream memory: holds off the first stall_cfg cycles of each transfer.
  assign m_waitrequest = (m_read | m_write) && (seen < stall_cfg);

  // Cycle (counted from the first request cycle) at which the request reaches m_*.
  function automatic int exp_fwd();
    if (!en_m) return 0;
    if (delay_m == 32'd0) return 1;
    return int'(delay_m) + 1;
  endfunction

  function automatic logic [31:0] exp_csr(input int a);
    if (a == 0) return {31'b0, en_m};
    if (a == 4) return delay_m;
    return 32'd0;
  endfunction

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
    if (a == 3'd0) en_m = d[0];
    else if (a == 3'd4) delay_m = d;
  endtask

  // Drives one upstream request until accepted; reports what was observed.
  task automatic run_txn(input bit is_wr, input int stall, input int clr_at,
                         input logic [31:0] mem_data, output int fwd, output int done,
                         output logic [31:0] rd, output bit path_ok, output bit strobe_ok);
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          req_was;
    a = $urandom; d = $urandom; be = 4'($urandom);
    fwd = -1; done = -1; rd = '0; path_ok = 1; strobe_ok = 1;
    seen = 0; stall_cfg = stall; m_readdata = mem_data;
    s_address = a; s_writedata = d; s_byteenable = be;
    s_write = is_wr; s_read = !is_wr;
    for (int k = 0; k < 200; k++) begin
      if (k == clr_at) begin
        csr_address = 3'd0; csr_writedata = 32'd0; csr_write = 1'b1;
      end
      @(negedge clk);
      req_was = m_read | m_write;
      if (m_address !== a || m_writedata !== d || m_byteenable !== be) path_ok = 0;
      if ((is_wr && m_read) || (!is_wr && m_write)) strobe_ok = 0;
      if (!req_was && fwd >= 0) strobe_ok = 0;
      if (req_was && fwd < 0) fwd = k;
      if (s_waitrequest === 1'b0) begin
        done = k; rd = s_readdata;
      end
      @(posedge clk); #1;
      csr_write = 1'b0;
      if (k == clr_at) en_m = 1'b0;
      if (req_was) seen++;
      if (done >= 0) break;
    end
    s_write = 1'b0; s_read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    csr_address = '0; csr_write = 0; csr_writedata = '0; csr_read = 0;
    s_address = '0; s_read = 0; s_write = 1'b1; s_writedata = '0; s_byteenable = '0;
    m_readdata = '0;
    en_m = 0; delay_m = 0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL reset m_write: got %b want 0", m_write); end
    n_chk++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL reset m_read: got %b want 0", m_read); end
    n_chk++; if (s_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset s_waitrequest: got %b want 1", s_waitrequest); end
    s_write = 1'b0;
    reset = 1'b1;
    csr_read = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_address = a[2:0]; #1;
      n_chk++;
      if (csr_readdata !== 32'd0) begin n_fail++; $display("FAIL reset csr[%0d]: got %h want 0", a, csr_readdata); end
    end
    csr_read = 1'b0;
  endtask

  task automatic test_csr();
    int others[6] = '{1, 2, 3, 5, 6, 7};
    csr_wr(3'd0, 32'hFFFF_FFFF);
    csr_wr(3'd4, 32'h1234_5678);
    foreach (others[i]) csr_wr(others[i][2:0], 32'hDEAD_BEEF);
    csr_read = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_address = a[2:0]; #1;
      n_chk++;
      if (csr_readdata !== exp_csr(a)) begin
        n_fail++; $display("FAIL csr readback[%0d]: got %h want %h", a, csr_readdata, exp_csr(a));
      end
    end
    csr_read = 1'b0;
    csr_wr(3'd0, 32'd0);
    csr_wr(3'd4, 32'd0);
  endtask

  task automatic test_passthrough();
    bit wr_t[3] = '{1, 1, 0};
    int st_t[3] = '{0, 2, 1};
    logic [31:0] md;
    for (int i = 0; i < 3; i++) begin
      md = $urandom; ef = exp_fwd();
      run_txn(wr_t[i], st_t[i], -1, md, f, dn, r, p, q);
      n_chk++; if (f !== ef) begin n_fail++; $display("FAIL pass fwd[%0d]: got %0d want %0d", i, f, ef); end
      n_chk++; if (dn !== ef + st_t[i]) begin n_fail++; $display("FAIL pass done[%0d]: got %0d want %0d", i, dn, ef + st_t[i]); end
      n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL pass path[%0d]: got %b%b want 11", i, p, q); end
      if (!wr_t[i]) begin
        n_chk++; if (r !== md) begin n_fail++; $display("FAIL pass rdata[%0d]: got %h want %h", i, r, md); end
      end
    end
  endtask

  task automatic test_delay();
    csr_wr(3'd4, 32'h1F);
    csr_wr(3'd0, 32'd1);
    ef = exp_fwd();
    run_txn(1'b1, 0, -1, 32'd0, f, dn, r, p, q);
    n_chk++; if (f !== 32) begin n_fail++; $display("FAIL delay write fwd: got %0d want 32 (model %0d)", f, ef); end
    n_chk++; if (dn !== ef) begin n_fail++; $display("FAIL delay write done: got %0d want %0d", dn, ef); end
    n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL delay write path: got %b%b want 11", p, q); end
    run_txn(1'b0, 3, -1, 32'hA5A5_A5A5, f, dn, r, p, q);
    n_chk++; if (f !== ef) begin n_fail++; $display("FAIL delay read fwd: got %0d want %0d", f, ef); end
    n_chk++; if (dn !== 35) begin n_fail++; $display("FAIL delay read done: got %0d want 35", dn); end
    n_chk++; if (r !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL delay read rdata: got %h want a5a5a5a5", r); end
    n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL delay read path: got %b%b want 11", p, q); end
  endtask

  task automatic test_disable();
    logic [31:0] md;
    csr_wr(3'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      md = $urandom; ef = exp_fwd();
      run_txn(i == 0, 1, -1, md, f, dn, r, p, q);
      n_chk++; if (f !== 0 || ef !== 0) begin n_fail++; $display("FAIL disable fwd[%0d]: got %0d want 0", i, f); end
      n_chk++; if (dn !== 1) begin n_fail++; $display("FAIL disable done[%0d]: got %0d want 1", i, dn); end
      n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL disable path[%0d]: got %b%b want 11", i, p, q); end
      if (i == 1) begin
        n_chk++; if (r !== md) begin n_fail++; $display("FAIL disable rdata: got %h want %h", r, md); end
      end
    end
  endtask

  task automatic test_zero_delay();
    csr_wr(3'd4, 32'd0);
    csr_wr(3'd0, 32'd1);
    for (int i = 0; i < 2; i++) begin
      ef = exp_fwd();
      run_txn(i == 0, 0, -1, 32'h0BAD_F00D, f, dn, r, p, q);
      n_chk++; if (f !== 1) begin n_fail++; $display("FAIL zero fwd[%0d]: got %0d want 1 (model %0d)", i, f, ef); end
      n_chk++; if (dn !== ef) begin n_fail++; $display("FAIL zero done[%0d]: got %0d want %0d", i, dn, ef); end
    end
  endtask

  task automatic test_clr_mid();
    csr_wr(3'd4, 32'd8);
    csr_wr(3'd0, 32'd1);
    ef = exp_fwd();
    run_txn(1'b1, 1, 3, 32'd0, f, dn, r, p, q);
    n_chk++; if (f !== ef) begin n_fail++; $display("FAIL clrmid fwd: got %0d want %0d", f, ef); end
    n_chk++; if (dn !== ef + 1) begin n_fail++; $display("FAIL clrmid done: got %0d want %0d", dn, ef + 1); end
    ef = exp_fwd();
    run_txn(1'b1, 0, -1, 32'd0, f, dn, r, p, q);
    n_chk++; if (f !== ef) begin n_fail++; $display("FAIL clrmid next fwd: got %0d want %0d", f, ef); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] md;
    csr_wr(3'd4, 32'd5);
    csr_wr(3'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      md = $urandom; ef = exp_fwd();
      run_txn(i[0], 0, -1, md, f, dn, r, p, q);
      n_chk++; if (f !== ef) begin n_fail++; $display("FAIL b2b fwd[%0d]: got %0d want %0d", i, f, ef); end
      n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL b2b path[%0d]: got %b%b want 11", i, p, q); end
    end
  endtask

  task automatic test_random();
    logic [31:0] md;
    bit w;
    int st;
    for (int i = 0; i < 12; i++) begin
      csr_wr(3'd4, $urandom_range(0, 7));
      csr_wr(3'd0, $urandom);
      w = 1'($urandom_range(0, 1)); st = $urandom_range(0, 3); md = $urandom;
      ef = exp_fwd();
      run_txn(w, st, -1, md, f, dn, r, p, q);
      n_chk++; if (f !== ef) begin n_fail++; $display("FAIL rand fwd[%0d]: got %0d want %0d", i, f, ef); end
      n_chk++; if (dn !== ef + st) begin n_fail++; $display("FAIL rand done[%0d]: got %0d want %0d", i, dn, ef + st); end
      n_chk++; if (!(p && q)) begin n_fail++; $display("FAIL rand path[%0d]: got %b%b want 11", i, p, q); end
      if (!w) begin
        n_chk++; if (r !== md) begin n_fail++; $display("FAIL rand rdata[%0d]: got %h want %h", i, r, md); end
      end
    end
  endtask

  task automatic test_reset_mid();
    csr_wr(3'd4, 32'd10);
    csr_wr(3'd0, 32'd1);
    seen = 0; stall_cfg = 0;
    s_address = $urandom; s_writedata = $urandom; s_byteenable = '1;
    s_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_chk++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL rstmid m_write: got %b want 0", m_write); end
    n_chk++; if (s_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rstmid s_waitrequest: got %b want 1", s_waitrequest); end
    @(posedge clk); #1;
    reset = 1'b1;
    en_m = 1'b0; delay_m = 32'd0;
    #1;
    n_chk++; if (m_write !== 1'b1) begin n_fail++; $display("FAIL rstmid pass m_write: got %b want 1", m_write); end
    n_chk++; if (s_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rstmid pass s_waitrequest: got %b want 0", s_waitrequest); end
    csr_read = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_address = a[2:0]; #1;
      n_chk++;
      if (csr_readdata !== exp_csr(a)) begin
        n_fail++; $display("FAIL rstmid csr[%0d]: got %h want %h", a, csr_readdata, exp_csr(a));
      end
    end
    csr_read = 1'b0;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csr();
    test_passthrough();
    test_delay();
    test_disable();
    test_zero_delay();
    test_clr_mid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
